// File: rtl/cache_lookup_ctrl_pkg.sv
// rtl/cache_lookup_ctrl_pkg.sv - shared cache geometry defaults and lookup FSM state encoding
package cache_lookup_ctrl_pkg;

   localparam int CACHE_ADDR_SIZE  = 32;
   localparam int CACHE_BLOCK_SIZE = 6;
   localparam int CACHE_INDEX_SIZE = 7;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOOKUP  = 3'd1,
      WB_REQ  = 3'd2,
      WB_WAIT = 3'd3,
      RF_REQ  = 3'd4,
      RF_WAIT = 3'd5,
      RESP    = 3'd6
   } state_t;

endpackage

// File: rtl/cache_lookup_ctrl_address_decode.sv
// rtl/cache_lookup_ctrl_address_decode.sv - splits a byte address into tag, set index and line offset
module address_decode
   import cache_lookup_ctrl_pkg::*;
#(
   parameter int ADDR_SIZE  = CACHE_ADDR_SIZE,
   parameter int BLOCK_SIZE = CACHE_BLOCK_SIZE,
   parameter int INDEX_SIZE = CACHE_INDEX_SIZE,
   parameter int TAG_SIZE   = ADDR_SIZE - BLOCK_SIZE - INDEX_SIZE
) (
   input  logic [ADDR_SIZE-1:0]  addr,
   output logic [TAG_SIZE-1:0]   tag,
   output logic [INDEX_SIZE-1:0] index,
   output logic [BLOCK_SIZE-1:0] offset
);

   assign tag    = addr[ADDR_SIZE-1 -: TAG_SIZE];
   assign index  = addr[BLOCK_SIZE +: INDEX_SIZE];
   assign offset = addr[BLOCK_SIZE-1:0];

endmodule

// File: rtl/cache_lookup_ctrl.sv
// rtl/cache_lookup_ctrl.sv - direct-mapped write-back cache lookup controller with victim write-back and refill
module cache_lookup_ctrl
   import cache_lookup_ctrl_pkg::*;
#(
   parameter int ADDR_SIZE  = CACHE_ADDR_SIZE,
   parameter int BLOCK_SIZE = CACHE_BLOCK_SIZE,
   parameter int INDEX_SIZE = CACHE_INDEX_SIZE,
   parameter int TAG_SIZE   = ADDR_SIZE - BLOCK_SIZE - INDEX_SIZE
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req_valid,
   output logic                  cpu_req_ready,
   input  logic [ADDR_SIZE-1:0]  cpu_req_addr,
   input  logic                  cpu_req_we,
   output logic                  cpu_resp_valid,
   output logic                  cpu_resp_hit,
   output logic [INDEX_SIZE-1:0] da_index,
   output logic [BLOCK_SIZE-1:0] da_offset,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_wb,
   output logic [ADDR_SIZE-1:0]  mem_req_addr,
   input  logic                  mem_done,
   input  logic                  flush
);

   localparam int SETS = 1 << INDEX_SIZE;

   state_t                 state;
   logic [ADDR_SIZE-1:0]   req_addr;
   logic                   req_we;
   logic [TAG_SIZE-1:0]    req_tag;
   logic [INDEX_SIZE-1:0]  req_idx;
   logic [BLOCK_SIZE-1:0]  req_off;
   logic [SETS-1:0]        valid_q;
   logic [SETS-1:0]        dirty_q;
   logic [TAG_SIZE-1:0]    tag_q [SETS];
   logic                   lookup_hit;

   address_decode #(
      .ADDR_SIZE  (ADDR_SIZE),
      .BLOCK_SIZE (BLOCK_SIZE),
      .INDEX_SIZE (INDEX_SIZE),
      .TAG_SIZE   (TAG_SIZE)
   ) u_decode (
      .addr   (req_addr),
      .tag    (req_tag),
      .index  (req_idx),
      .offset (req_off)
   );

   // valid gates the compare, so the unreset tag array never leaks X into a hit
   assign lookup_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign cpu_req_ready = (state == IDLE);
   assign da_index      = req_idx;
   assign da_offset     = req_off;

   always_ff @(posedge clk) begin
      if (state == RF_WAIT && mem_done) begin
         tag_q[req_idx] <= req_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         req_addr       <= '0;
         req_we         <= 1'b0;
         valid_q        <= '0;
         dirty_q        <= '0;
         cpu_resp_valid <= 1'b0;
         cpu_resp_hit   <= 1'b0;
         mem_req_valid  <= 1'b0;
         mem_req_wb     <= 1'b0;
         mem_req_addr   <= '0;
      end else begin
         cpu_resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (flush) begin
                  valid_q <= '0;
                  dirty_q <= '0;
               end else if (cpu_req_valid) begin
                  req_addr <= cpu_req_addr;
                  req_we   <= cpu_req_we;
                  state    <= LOOKUP;
               end
            end
            LOOKUP: begin
               cpu_resp_hit <= lookup_hit;
               if (lookup_hit) begin
                  cpu_resp_valid <= 1'b1;
                  state          <= RESP;
               end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                  mem_req_valid <= 1'b1;
                  mem_req_wb    <= 1'b1;
                  mem_req_addr  <= {tag_q[req_idx], req_idx, {BLOCK_SIZE{1'b0}}};
                  state         <= WB_REQ;
               end else begin
                  mem_req_valid <= 1'b1;
                  mem_req_wb    <= 1'b0;
                  mem_req_addr  <= {req_tag, req_idx, {BLOCK_SIZE{1'b0}}};
                  state         <= RF_REQ;
               end
            end
            WB_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WB_WAIT;
               end
            end
            WB_WAIT: begin
               if (mem_done) begin
                  dirty_q[req_idx] <= 1'b0;
                  mem_req_valid    <= 1'b1;
                  mem_req_wb       <= 1'b0;
                  mem_req_addr     <= {req_tag, req_idx, {BLOCK_SIZE{1'b0}}};
                  state            <= RF_REQ;
               end
            end
            RF_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= RF_WAIT;
               end
            end
            RF_WAIT: begin
               if (mem_done) begin
                  valid_q[req_idx] <= 1'b1;
                  cpu_resp_valid   <= 1'b1;
                  state            <= RESP;
               end
            end
            RESP: begin
               if (req_we) begin
                  dirty_q[req_idx] <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
